lab_stats: RTL

LAB_STATS -- requirements
Module: lab_stats

---
 rtl/lab_stats.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/lab_stats.sv
`default_nettype none
// ============================================================================
//  Module   : lab_stats
//  Purpose  : Per-frame mean and variance of the L, a and b channels of a
//             Q3.13 Lab pixel stream (N = 2^LOG2_NPIX pixels per frame).
//  Ports    : i_clk, i_rst            - clock, synchronous active-high reset
//             i_valid, i_l/i_a/i_b    - input pixel handshake and data
//             o_ready                 - pixel accepted when i_valid & o_ready
//             o_valid                 - one-cycle pulse, results updated
//             o_mean_*                - frame mean, signed Q3.13
//             o_var_*                 - frame variance, unsigned Q3.13, sat.
//  Revision : 1.0 - initial release
// ============================================================================
module lab_stats #(
    parameter int LOG2_NPIX = 18
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic [15:0] i_l,
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic        o_ready,
    output logic        o_valid,
    output logic [15:0] o_mean_l,
    output logic [15:0] o_mean_a,
    output logic [15:0] o_mean_b,
    output logic [15:0] o_var_l,
    output logic [15:0] o_var_a,
    output logic [15:0] o_var_b
);

    localparam int SW = LOG2_NPIX + 16;    // signed sum width
    localparam int QW = LOG2_NPIX + 32;    // unsigned sum-of-squares width

    localparam logic [1:0] S_ACCUM = 2'd0;
    localparam logic [1:0] S_CALC  = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]           r_state;
    logic [LOG2_NPIX-1:0] r_cnt;
    logic [2:0]           r_step;

    logic signed [SW-1:0] r_sum_l, r_sum_a, r_sum_b;
    logic [QW-1:0]        r_sq_l,  r_sq_a,  r_sq_b;

    // Intermediate results held during CALC so outputs only move at its end
    logic signed [15:0]   r_mean_l, r_mean_a, r_mean_b;
    logic [31:0]          r_msq;
    logic [15:0]          r_var_l, r_var_a;

    logic                 w_accept;
    logic signed [31:0]   w_sq_l, w_sq_a, w_sq_b;
    logic signed [SW-1:0] w_sum_sel;
    logic [QW-1:0]        w_sq_sel;
    logic signed [15:0]   w_mean;
    logic [31:0]          w_msq;
    logic signed [15:0]   w_mean_sel;
    logic signed [31:0]   w_prod;
    logic signed [33:0]   w_diff;
    logic [20:0]          w_vsh;
    logic [15:0]          w_var;

    assign o_ready  = (r_state == S_ACCUM) && !i_rst;
    assign o_valid  = (r_state == S_DONE);
    assign w_accept = i_valid && o_ready;

    // Squares of 16-bit signed values never exceed 2^30, so they are
    // non-negative in 32 bits and can be zero-extended into the sums.
    assign w_sq_l = $signed(i_l) * $signed(i_l);
    assign w_sq_a = $signed(i_a) * $signed(i_a);
    assign w_sq_b = $signed(i_b) * $signed(i_b);

    // Channel selection for CALC: r_step[2:1] = 0 (l), 1 (a), 2 (b)
    always_comb begin
        w_sum_sel  = r_sum_b;
        w_sq_sel   = r_sq_b;
        w_mean_sel = r_mean_b;
        case (r_step[2:1])
            2'd0: begin
                w_sum_sel  = r_sum_l;
                w_sq_sel   = r_sq_l;
                w_mean_sel = r_mean_l;
            end
            2'd1: begin
                w_sum_sel  = r_sum_a;
                w_sq_sel   = r_sq_a;
                w_mean_sel = r_mean_a;
            end
            default: ;
        endcase
    end

    // Step A: floor mean (Q3.13) and mean of squares (Q6.26)
    assign w_mean = 16'(w_sum_sel >>> LOG2_NPIX);
    assign w_msq  = 32'(w_sq_sel >> LOG2_NPIX);

    // Step B: the single shared multiplier squares the stored mean
    assign w_prod = w_mean_sel * w_mean_sel;
    assign w_diff = $signed({2'b00, r_msq}) - $signed({{2{w_prod[31]}}, w_prod});
    assign w_vsh  = 21'(w_diff >>> 13);

    // w_vsh[20] is the sign of the difference; bits 19:16 flag overflow
    always_comb begin
        w_var = w_vsh[15:0];
        if (w_vsh[20]) begin
            w_var = 16'h0000;
        end else if (|w_vsh[19:16]) begin
            w_var = 16'hFFFF;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_ACCUM;
            r_cnt    <= '0;
            r_step   <= 3'd0;
            r_sum_l  <= '0;
            r_sum_a  <= '0;
            r_sum_b  <= '0;
            r_sq_l   <= '0;
            r_sq_a   <= '0;
            r_sq_b   <= '0;
            r_mean_l <= '0;
            r_mean_a <= '0;
            r_mean_b <= '0;
            r_msq    <= '0;
            r_var_l  <= '0;
            r_var_a  <= '0;
            o_mean_l <= '0;
            o_mean_a <= '0;
            o_mean_b <= '0;
            o_var_l  <= '0;
            o_var_a  <= '0;
            o_var_b  <= '0;
        end else begin
            case (r_state)
                S_ACCUM: begin
                    if (w_accept) begin
                        r_sum_l <= r_sum_l + {{LOG2_NPIX{i_l[15]}}, i_l};
                        r_sum_a <= r_sum_a + {{LOG2_NPIX{i_a[15]}}, i_a};
                        r_sum_b <= r_sum_b + {{LOG2_NPIX{i_b[15]}}, i_b};
                        r_sq_l  <= r_sq_l + {{LOG2_NPIX{1'b0}}, w_sq_l};
                        r_sq_a  <= r_sq_a + {{LOG2_NPIX{1'b0}}, w_sq_a};
                        r_sq_b  <= r_sq_b + {{LOG2_NPIX{1'b0}}, w_sq_b};
                        // Counter wraps to 0 on the Nth accept
                        r_cnt   <= r_cnt + LOG2_NPIX'(1);
                        if (r_cnt == '1) begin
                            r_state <= S_CALC;
                            r_step  <= 3'd0;
                        end
                    end
                end
                S_CALC: begin
                    r_step <= r_step + 3'd1;
                    if (!r_step[0]) begin
                        r_msq <= w_msq;
                        case (r_step[2:1])
                            2'd0:    r_mean_l <= w_mean;
                            2'd1:    r_mean_a <= w_mean;
                            default: r_mean_b <= w_mean;
                        endcase
                    end else begin
                        case (r_step[2:1])
                            2'd0:    r_var_l <= w_var;
                            2'd1:    r_var_a <= w_var;
                            default: ;
                        endcase
                    end
                    // Last step: b variance is taken straight from w_var
                    if (r_step == 3'd5) begin
                        o_mean_l <= r_mean_l;
                        o_mean_a <= r_mean_a;
                        o_mean_b <= r_mean_b;
                        o_var_l  <= r_var_l;
                        o_var_a  <= r_var_a;
                        o_var_b  <= w_var;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_ACCUM;
                    r_step  <= 3'd0;
                    r_sum_l <= '0;
                    r_sum_a <= '0;
                    r_sum_b <= '0;
                    r_sq_l  <= '0;
                    r_sq_a  <= '0;
                    r_sq_b  <= '0;
                end
                default: r_state <= S_ACCUM;
            endcase
        end
    end

endmodule
`default_nettype wire
